// File: rtl/coletor_senha.sv
// coletor_senha: gathers keypad digits into a password buffer and hands it to the verifier.
// Optional failed-attempt lockout is enabled by defining ATTEMPT_LOCK_EN.
module coletor_senha #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_TENTATIVAS = 3,
    parameter int LOCK_CYCLES    = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        done_in,
    input  logic        senha_ok_in,
    output logic [79:0] senha_out,
    output logic        valid_out,
    output logic        busy,
    output logic [4:0]  n_digits,
    output logic        result_valid,
    output logic        result_ok,
    output logic        bloqueado
);

    localparam int MAX_WAIT = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(MAX_WAIT) + 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_SAT = '1;
`ifdef ATTEMPT_LOCK_EN
    localparam int FW = $clog2(MAX_TENTATIVAS + 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        COLETANDO,
        ENVIANDO,
        AGUARDANDO,
        RESULTADO
`ifdef ATTEMPT_LOCK_EN
        , BLOQUEADO
`endif
    } state_t;

    state_t          state, state_n;
    logic [79:0]     buf_n;
    logic [4:0]      n_n;
    logic [TW-1:0]   timer, timer_n, t_inc;
    logic            valid_n, rv_n, rok_n, busy_n;
    logic [6:0]      wr_base, bs_base;
    logic            is_digit, is_bksp, is_enter;
`ifdef ATTEMPT_LOCK_EN
    logic [FW-1:0]   fail_cnt, fail_n;
    logic            bloq_n;
`endif

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_bksp  = key_valid && (key_code == 4'hA);
    assign is_enter = key_valid && (key_code == 4'hB);
    assign wr_base  = {n_digits, 2'b00};
    assign bs_base  = {n_digits - 5'd1, 2'b00};
    assign t_inc    = (timer == TIMER_SAT) ? timer : timer + 1'b1;
    assign busy_n   = (state_n != IDLE) && (state_n != COLETANDO);
`ifdef ATTEMPT_LOCK_EN
    assign bloq_n   = (state_n == BLOQUEADO);
`else
    assign bloqueado = 1'b0;
`endif

    // State, buffer, timer and all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            senha_out    <= '1;
            n_digits     <= '0;
            timer        <= '0;
            valid_out    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_ok    <= 1'b0;
`ifdef ATTEMPT_LOCK_EN
            fail_cnt     <= '0;
            bloqueado    <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            senha_out    <= buf_n;
            n_digits     <= n_n;
            timer        <= timer_n;
            valid_out    <= valid_n;
            busy         <= busy_n;
            result_valid <= rv_n;
            result_ok    <= rok_n;
`ifdef ATTEMPT_LOCK_EN
            fail_cnt     <= fail_n;
            bloqueado    <= bloq_n;
`endif
        end
    end

    // Next-state logic; pulses are raised on entry so they line up with their state.
    always_comb begin
        state_n = state;
        buf_n   = senha_out;
        n_n     = n_digits;
        timer_n = timer;
        valid_n = 1'b0;
        rv_n    = 1'b0;
        rok_n   = result_ok;
`ifdef ATTEMPT_LOCK_EN
        fail_n  = fail_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (is_digit) begin
                    buf_n   = {{19{4'hF}}, key_code};
                    n_n     = 5'd1;
                    timer_n = '0;
                    state_n = COLETANDO;
                end
            end
            COLETANDO: begin
                if (is_digit) begin
                    timer_n = '0;
                    if (n_digits == 5'd20) begin
                        buf_n = {key_code, senha_out[79:4]};
                    end else begin
                        buf_n[wr_base +: 4] = key_code;
                        n_n = n_digits + 5'd1;
                    end
                end else if (is_bksp) begin
                    timer_n = '0;
                    buf_n[bs_base +: 4] = 4'hF;
                    n_n = n_digits - 5'd1;
                    if (n_digits == 5'd1) state_n = IDLE;
                end else if (is_enter) begin
                    timer_n = '0;
                    valid_n = 1'b1;
                    state_n = ENVIANDO;
                end else if (timer == TO_LAST) begin
                    buf_n   = '1;
                    n_n     = '0;
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = t_inc;
                end
            end
            ENVIANDO: begin
                timer_n = '0;
                state_n = AGUARDANDO;
            end
            AGUARDANDO: begin
                if (done_in || (timer == TO_LAST)) begin
                    rok_n   = done_in & senha_ok_in;
                    rv_n    = 1'b1;
                    buf_n   = '1;
                    n_n     = '0;
                    timer_n = '0;
                    state_n = RESULTADO;
`ifdef ATTEMPT_LOCK_EN
                    if (done_in && senha_ok_in) fail_n = '0;
                    else fail_n = fail_cnt + FW'(1);
`endif
                end else begin
                    timer_n = t_inc;
                end
            end
            RESULTADO: begin
`ifdef ATTEMPT_LOCK_EN
                timer_n = '0;
                if (fail_cnt >= FW'(MAX_TENTATIVAS)) state_n = BLOQUEADO;
                else state_n = IDLE;
`else
                state_n = IDLE;
`endif
            end
`ifdef ATTEMPT_LOCK_EN
            BLOQUEADO: begin
                if (timer == LOCK_LAST) begin
                    fail_n  = '0;
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = t_inc;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_coletor_senha.sv
// tb_coletor_senha: directed and random key sequences for coletor_senha,
// checked against a queue-based model of the typed password.
module tb_coletor_senha;

    localparam int T    = 16;
    localparam int MAXT = 3;
    localparam int LOCK = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        done_in = 1'b0;
    logic        senha_ok_in = 1'b0;
    logic [79:0] senha_out;
    logic        valid_out;
    logic        busy;
    logic [4:0]  n_digits;
    logic        result_valid;
    logic        result_ok;
    logic        bloqueado;

    coletor_senha #(
        .TIMEOUT_CYCLES(T),
        .MAX_TENTATIVAS(MAXT),
        .LOCK_CYCLES(LOCK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_valid(key_valid),
        .key_code(key_code),
        .done_in(done_in),
        .senha_ok_in(senha_ok_in),
        .senha_out(senha_out),
        .valid_out(valid_out),
        .busy(busy),
        .n_digits(n_digits),
        .result_valid(result_valid),
        .result_ok(result_ok),
        .bloqueado(bloqueado)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int q[$];
    int fails_model = 0;
    logic [79:0] all_f = '1;

    function automatic logic [79:0] pack();
        logic [79:0] r;
        r = '1;
        foreach (q[i]) r[4*i +: 4] = 4'(q[i]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic key(input int k);
        press(4'(k));
        if (k <= 9) begin
            q.push_back(k);
            if (q.size() > 20) void'(q.pop_front());
        end else if (k == 10 && q.size() > 0) begin
            void'(q.pop_back());
        end
        chk("n_digits", n_digits, q.size());
        chk("senha", senha_out, pack());
        chk("idle_valid", valid_out, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic lock_seq();
        int c;
        chk("lock_on", bloqueado, 1);
        chk("lock_busy", busy, 1);
        c = 0;
        repeat (3) begin
            press(4'($urandom_range(0, 9)));
            c++;
            chk("lock_keys_dropped", n_digits, 0);
            chk("lock_held", bloqueado, 1);
        end
        while (bloqueado && c < LOCK + 5) begin
            @(negedge clk);
            c++;
        end
        chk("lock_cycles", c, LOCK);
        chk("lock_busy_off", busy, 0);
        fails_model = 0;
    endtask

    task automatic enter(input bit ok, input bit use_done, input int nkeys, input bit early);
        logic [79:0] exp;
        int c;
        exp = pack();
        press(4'hB);
        chk("valid_pulse", valid_out, 1);
        chk("busy_env", busy, 1);
        chk("senha_sent", senha_out, exp);
        if (early) begin
            done_in = 1'b1;
            senha_ok_in = 1'b1;
        end
        @(negedge clk);
        done_in = 1'b0;
        c = 0;
        chk("valid_once", valid_out, 0);
        chk("no_early_result", result_valid, 0);
        repeat (nkeys) begin
            press(4'($urandom_range(0, 11)));
            c++;
            chk("senha_frozen", senha_out, exp);
            chk("busy_wait", busy, 1);
        end
        if (use_done) begin
            done_in = 1'b1;
            senha_ok_in = ok;
            @(negedge clk);
            done_in = 1'b0;
            senha_ok_in = 1'($urandom_range(0, 1));
        end else begin
            while (!result_valid && c < T + 5) begin
                @(negedge clk);
                c++;
            end
            chk("timeout_cycles", c, T);
            ok = 1'b0;
        end
        chk("result_valid", result_valid, 1);
        chk("result_ok", result_ok, ok);
        chk("n_cleared", n_digits, 0);
        chk("senha_cleared", senha_out, all_f);
        q.delete();
        @(negedge clk);
        chk("result_pulse", result_valid, 0);
        chk("result_held", result_ok, ok);
`ifdef ATTEMPT_LOCK_EN
        fails_model = ok ? 0 : fails_model + 1;
        if (fails_model >= MAXT) begin
            lock_seq();
        end else begin
            chk("busy_after", busy, 0);
            chk("no_lock", bloqueado, 0);
        end
`else
        chk("busy_after", busy, 0);
        chk("no_lock", bloqueado, 0);
`endif
    endtask

    initial begin
        int c;
        bit sawv;
        int len;
        int r;
        logic [79:0] snap;

        repeat (2) @(negedge clk);
        chk("rst_n", n_digits, 0);
        chk("rst_senha", senha_out, all_f);
        chk("rst_valid", valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_rok", result_ok, 0);
        chk("rst_bloq", bloqueado, 0);
        rst = 1'b0;
        @(negedge clk);

        // basic entry and success
        for (int i = 1; i <= 4; i++) key(i);
        enter(1'b1, 1'b1, 0, 1'b0);

        // backspace, including an ignored one in IDLE
        key(10);
        key(1); key(2); key(3); key(10); key(9);
        snap = pack();
        chk("bksp_digits", snap[15:0], 16'hF921);
        enter(1'b0, 1'b1, 2, 1'b0);

        // overflow shifting past 20 digits
        for (int i = 0; i < 22; i++) key(i < 20 ? i % 10 : (i == 20 ? 7 : 8));
        chk("ovf_n", n_digits, 20);
        snap = senha_out;
        chk("ovf_d0", snap[3:0], 2);
        chk("ovf_d18", snap[75:72], 7);
        chk("ovf_d19", snap[79:76], 8);
        key(10);
        key(12);
        enter(1'b1, 1'b1, 1, 1'b0);

        // response timeout, done during ENVIANDO ignored
        key(5);
        enter(1'b1, 1'b0, 3, 1'b1);

        // failure counting with an intermediate success
        key(1); enter(1'b1, 1'b1, 0, 1'b0);
        key(2); enter(1'b0, 1'b1, 0, 1'b0);
        key(3); enter(1'b0, 1'b1, 0, 1'b0);
        key(4); enter(1'b1, 1'b1, 0, 1'b0);
        key(5); enter(1'b0, 1'b1, 0, 1'b0);
        key(6); enter(1'b0, 1'b1, 0, 1'b0);
        key(7); enter(1'b0, 1'b1, 1, 1'b0);
        key(8); enter(1'b1, 1'b1, 0, 1'b0);

        // inactivity timeout while collecting
        key(3);
        c = 0;
        sawv = 1'b0;
        while (n_digits != 0 && c < T + 5) begin
            @(negedge clk);
            c++;
            if (valid_out) sawv = 1'b1;
        end
        q.delete();
        chk("idle_timeout", c, T);
        chk("idle_no_valid", sawv, 0);
        chk("idle_cleared", senha_out, all_f);
        chk("idle_busy0", busy, 0);

        // random sessions
        repeat (8) begin
            len = $urandom_range(1, 24);
            for (int j = 0; j < len; j++) begin
                r = $urandom_range(0, 15);
                if (r == 11) r = 10;
                key(r);
            end
            if (q.size() == 0) key($urandom_range(0, 9));
            enter(1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 2), 1'b0);
        end

        // asynchronous reset while waiting for the verifier
        key(9); enter(1'b1, 1'b1, 0, 1'b0);
        key(7);
        press(4'hB);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_n", n_digits, 0);
        chk("arst_senha", senha_out, all_f);
        chk("arst_busy", busy, 0);
        chk("arst_valid", valid_out, 0);
        chk("arst_rv", result_valid, 0);
        chk("arst_rok", result_ok, 0);
        chk("arst_bloq", bloqueado, 0);
        q.delete();
        fails_model = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        key(6);
        enter(1'b1, 1'b1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
